// File: rtl/arb_pkg.sv
// Shared types and the round-robin search used by the decoder-select arbiter.
package arb_pkg;

    localparam int IDXW_DEF = 3;
    localparam int NREQ_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                found;
        logic [IDXW_DEF-1:0] idx;
    } pick_t;

    // First set request at or above ptr, wrapping at nreq; lowest offset wins.
    function automatic pick_t rr_pick(input logic [NREQ_DEF-1:0] req,
                                      input logic [IDXW_DEF-1:0] ptr,
                                      input int                  nreq);
        pick_t res;
        int    cand;
        res = '0;
        for (int k = NREQ_DEF - 1; k >= 0; k--) begin
            if (k < nreq) begin
                cand = (int'(ptr) + k) % nreq;
                if (req[cand[IDXW_DEF-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = cand[IDXW_DEF-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_decode_arbiter_dec.sv
// Index-to-one-hot decoder driving the chip-select/enable fabric.
module rr_decode_arbiter_dec #(
    parameter int IDXW = 3,
    parameter int NOUT = 8
) (
    input  logic [IDXW-1:0] a,
    output logic [NOUT-1:0] y
);

    always_comb begin
        y    = '0;
        y[a] = 1'b1;
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one decoder select among NREQ requesters,
// with optional hold-time preemption and a dead cycle between grants.
module rr_decode_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int IDXW     = IDXW_DEF,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic [NREQ-1:0] gnt_onehot,
    output logic            preempt,
    output logic            busy
);

    localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD < 1) ? '0 : HCW'(MAX_HOLD - 1);

    arb_state_t      state, nstate;
    logic [IDXW-1:0] ptr, ptr_d, idx_d;
    logic [HCW-1:0]  hold_cnt, hold_d;
    logic            valid_d, preempt_d, busy_d;
    logic [NREQ-1:0] dec_y;
    logic [NREQ_DEF-1:0] req_ext;
    logic [IDXW_DEF-1:0] ptr_ext;
    pick_t           pick;
    logic            rel, others, pre_hit;

    rr_decode_arbiter_dec #(.IDXW(IDXW), .NOUT(NREQ)) u_dec (
        .a (gnt_idx),
        .y (dec_y)
    );

    assign gnt_onehot = dec_y & {NREQ{gnt_valid}};

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        ptr_ext             = '0;
        ptr_ext[IDXW-1:0]   = ptr;
        pick    = rr_pick(req_ext, ptr_ext, NREQ);
        rel     = ~req[gnt_idx];
        others  = |(req & ~dec_y);
        pre_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && others;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
            preempt   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nstate;
            gnt_valid <= valid_d;
            gnt_idx   <= idx_d;
            ptr       <= ptr_d;
            hold_cnt  <= hold_d;
            preempt   <= preempt_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (pick.found) nstate = GRANT;
            GRANT:   if (rel || pre_hit) nstate = RELEASE;
            RELEASE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // A release coinciding with a preemption is reported as a normal release.
    always_comb begin
        valid_d   = (nstate == GRANT);
        busy_d    = (nstate != IDLE);
        idx_d     = gnt_idx;
        ptr_d     = ptr;
        hold_d    = '0;
        preempt_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick.found) idx_d = pick.idx[IDXW-1:0];
            end
            GRANT: begin
                preempt_d = pre_hit && !rel;
                if (nstate == GRANT)
                    hold_d = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + HCW'(1);
            end
            RELEASE: begin
                ptr_d = gnt_idx + IDXW'(1);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Randomized and directed bench for rr_decode_arbiter against a grant-level model.
module tb_rr_decode_arbiter;

    localparam int NREQ     = 8;
    localparam int IDXW     = 3;
    localparam int MAX_HOLD = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic            gnt_valid, preempt, busy;
    logic [IDXW-1:0] gnt_idx;
    logic [NREQ-1:0] gnt_onehot;

    int errors = 0;
    int checks = 0;

    rr_decode_arbiter #(.NREQ(NREQ), .IDXW(IDXW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .preempt    (preempt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Grant-level model: who owns the select, for how long, and the gap after.
    typedef struct {
        bit owned;
        bit gap;
        bit pre;
        int owner;
        int len;
        int ptr;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t s, logic [NREQ-1:0] r);
        model_t n;
        bit     done, revoke;
        n     = s;
        n.pre = 1'b0;
        if (s.owned) begin
            done   = (r[s.owner] == 1'b0);
            revoke = (MAX_HOLD != 0) && (s.len >= MAX_HOLD - 1) &&
                     ((r & ~(8'd1 << s.owner)) != 8'd0);
            if (done || revoke) begin
                n.owned = 1'b0;
                n.gap   = 1'b1;
                n.pre   = revoke && !done;
            end else begin
                n.len = s.len + 1;
            end
        end else if (s.gap) begin
            n.gap = 1'b0;
            n.ptr = (s.owner + 1) % NREQ;
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (r[(s.ptr + k) % NREQ]) begin
                    n.owned = 1'b1;
                    n.owner = (s.ptr + k) % NREQ;
                    n.len   = 0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '{default: 0};
        else      m <= model_next(m, req);
    end

    logic [13:0] act_out, exp_out;
    logic [2:0]  e_idx;
    logic [7:0]  e_hot;
    assign act_out = {busy, preempt, gnt_valid, gnt_idx, gnt_onehot};
    always_comb begin
        e_idx   = 3'(m.owner);
        e_hot   = m.owned ? (8'd1 << e_idx) : 8'd0;
        exp_out = {m.owned | m.gap, m.pre, m.owned, e_idx, e_hot};
    end

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_valid(input bit v, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (gnt_valid === v) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (gnt_valid !== 1'b0 || gnt_onehot !== 8'h00 || busy !== 1'b0 || gnt_idx !== 3'd0 || preempt !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: valid=%b onehot=%h busy=%b idx=%0d preempt=%b, want all zero",
                         gnt_valid, gnt_onehot, busy, gnt_idx, preempt);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0 || gnt_onehot !== 8'h01) begin
            errors++;
            $display("FAIL reset_first_grant: valid=%b idx=%0d onehot=%h, want 1/0/01", gnt_valid, gnt_idx, gnt_onehot);
        end
        checks++;
        if (act_out !== exp_out) begin
            errors++;
            $display("FAIL reset_model: got %h want %h", act_out, exp_out);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int expo[4] = '{0, 2, 7, 0};
        int held = 0, gap = 0, min_gap = 99;
        bit prev = 1'b0;
        do_reset();
        req = 8'h85;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            checks++;
            if (act_out !== exp_out) begin
                errors++;
                $display("FAIL rr_model cyc %0d: got %h want %h", c, act_out, exp_out);
            end
            if (gnt_valid) begin
                if (!prev) begin
                    order.push_back(int'(gnt_idx));
                    if (order.size() > 1 && gap < min_gap) min_gap = gap;
                    held = 0;
                end
                held++;
                gap = 0;
                req = (held == 2) ? (8'h85 & ~(8'd1 << gnt_idx)) : 8'h85;
            end else begin
                gap++;
                req = 8'h85;
            end
            prev = gnt_valid;
        end
        checks++;
        if (order.size() != 4) begin
            errors++;
            $display("FAIL rr_count: saw %0d grants, want 4", order.size());
        end
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            checks++;
            if (order[i] != expo[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], expo[i]);
            end
        end
        checks++;
        if (min_gap < 1) begin
            errors++;
            $display("FAIL rr_gap: smallest gap %0d cycles, want >= 1", min_gap);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        req = 8'h40;
        wait_valid(1'b1, 10, ok);
        checks++;
        if (!ok || gnt_idx !== 3'd6) begin
            errors++;
            $display("FAIL wrap_setup: ok=%b idx=%0d, want grant 6", ok, gnt_idx);
        end
        req = 8'h02;
        wait_valid(1'b0, 10, ok);
        wait_valid(1'b1, 10, ok);
        checks++;
        if (!ok || gnt_idx !== 3'd1 || gnt_onehot !== 8'h02) begin
            errors++;
            $display("FAIL wrap_grant: ok=%b idx=%0d onehot=%h, want 1/02", ok, gnt_idx, gnt_onehot);
        end
        checks++;
        if (act_out !== exp_out) begin
            errors++;
            $display("FAIL wrap_model: got %h want %h", act_out, exp_out);
        end
    endtask

    task automatic test_preempt();
        int grants[$];
        int held = 0, first_len = 0, pre_cnt = 0;
        bit prev = 1'b0, pre_at_rel = 1'b0;
        do_reset();
        req = 8'h08;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if (act_out !== exp_out) begin
                errors++;
                $display("FAIL pre_model cyc %0d: got %h want %h", c, act_out, exp_out);
            end
            if (gnt_valid) begin
                if (!prev) begin
                    grants.push_back(int'(gnt_idx));
                    held = 0;
                end
                held++;
                if (grants.size() == 1 && held == 2) req = 8'h28;
                if (gnt_idx == 3'd5 && held == 2) req = 8'h08;
            end else if (prev && grants.size() == 1) begin
                first_len  = held;
                pre_at_rel = preempt;
            end
            if (preempt) pre_cnt++;
            prev = gnt_valid;
        end
        checks++;
        if (first_len != MAX_HOLD || pre_at_rel !== 1'b1) begin
            errors++;
            $display("FAIL pre_first: len=%0d preempt=%b, want %0d/1", first_len, pre_at_rel, MAX_HOLD);
        end
        checks++;
        if (grants.size() != 3 || grants[1] != 5 || grants[2] != 3) begin
            errors++;
            $display("FAIL pre_order: count=%0d, want 3 grants 3,5,3", grants.size());
        end
        checks++;
        if (pre_cnt != 1) begin
            errors++;
            $display("FAIL pre_pulses: got %0d want 1", pre_cnt);
        end
    endtask

    task automatic test_simultaneous();
        int grants[$];
        int held = 0, rel_len = 0;
        bit prev = 1'b0, rel_pre = 1'b1, ok;
        do_reset();
        req = 8'h08;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (act_out !== exp_out) begin
                errors++;
                $display("FAIL sim_model cyc %0d: got %h want %h", c, act_out, exp_out);
            end
            if (gnt_valid) begin
                if (!prev) begin
                    grants.push_back(int'(gnt_idx));
                    held = 0;
                end
                held++;
                if (grants.size() == 1 && held == 2) req = 8'h28;
                if (grants.size() == 1 && held == 4) req = 8'h20;
            end else if (prev && grants.size() == 1) begin
                rel_len = held;
                rel_pre = preempt;
            end
            prev = gnt_valid;
        end
        checks++;
        if (rel_pre !== 1'b0 || rel_len != 4 || grants.size() < 2 || grants[1] != 5) begin
            errors++;
            $display("FAIL sim_release: preempt=%b len=%0d grants=%0d, want 0/4 then 5", rel_pre, rel_len, grants.size());
        end
        do_reset();
        req = 8'h10;
        wait_valid(1'b1, 10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sole_start: no grant within 10 cycles, want grant 4");
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'd4 || preempt !== 1'b0 || act_out !== exp_out) begin
                errors++;
                $display("FAIL sole_hold cyc %0d: valid=%b idx=%0d preempt=%b, want 1/4/0", c, gnt_valid, gnt_idx, preempt);
            end
        end
    endtask

    task automatic test_reset_mid();
        int grants = 0, held = 0;
        bit prev = 1'b0, ok;
        do_reset();
        req = 8'h0C;
        for (int c = 0; c < 30 && grants < 3; c++) begin
            @(negedge clk);
            if (gnt_valid) begin
                if (!prev) begin
                    grants++;
                    held = 0;
                end
                held++;
                if (grants == 1 && held == 2) req = 8'h08;
                if (grants == 2 && held == 2) req = 8'h04;
            end
            prev = gnt_valid;
        end
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2) begin
            errors++;
            $display("FAIL mid_setup: valid=%b idx=%0d, want grant 2", gnt_valid, gnt_idx);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (act_out !== 14'h0) begin
            errors++;
            $display("FAIL mid_async_clear: got %h want 0000", act_out);
        end
        @(negedge clk);
        req = 8'h0C;
        rst = 1'b1;
        wait_valid(1'b1, 10, ok);
        checks++;
        if (!ok || gnt_idx !== 3'd2 || gnt_onehot !== 8'h04) begin
            errors++;
            $display("FAIL mid_regrant: ok=%b idx=%0d onehot=%h, want 2/04", ok, gnt_idx, gnt_onehot);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checks++;
            if (act_out !== exp_out) begin
                errors++;
                $display("FAIL rand_model cyc %0d: got %h want %h (req=%h)", c, act_out, exp_out, req);
            end
            if ($urandom_range(0, 3) == 0) req = req ^ (8'd1 << $urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) req = 8'($urandom);
            if (c == 300) rst = 1'b0;
            if (c == 302) rst = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_preempt();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
